spi_slave: RTL and testbench

Oversampled SPI slave that sits directly downstream of spi_master and consumes its cs/spi_clk/mosi frame stream. It returns bytes on miso. All four CPOL/CPHA modes are supported, selected by the same polarity/phase controls the master uses. The block synchronises the SPI pins into the system clock domain, shifts MSB-first, and presents each received word with a one-cycle valid strobe to local logic.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_slave.sv | 169 ++++++++++++++++
 tb/tb_spi_slave.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, latched bus mode and default word width.
package spi_pkg;

   localparam int SPI_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      DONE    = 2'd2,
      WAIT_CS = 2'd3
   } spi_state_t;

   typedef struct packed {
      logic polarity;
      logic phase;
   } spi_mode_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchroniser with one extra registered copy for rise/fall pulse detection.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_din,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI slave, all four CPOL/CPHA modes, MSB-first, multi-word frames.
// Optional SPI_SLAVE_OVERRUN_EN adds a pending bit cleared by rx_ack and a sticky overrun flag.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_polarity,
   input  logic                  i_phase,
   input  logic                  i_spi_clk,
   input  logic                  i_cs,
   input  logic                  i_mosi,
   output logic                  o_miso,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   output logic                  o_tx_load,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   output logic                  o_rx_valid,
   input  logic                  i_rx_ack,
   output logic                  o_overrun,
   output logic                  o_busy,
   output logic [1:0]            o_state,
   output logic [3:0]            o_count
);

   localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
   localparam logic [3:0] FULL     = 4'(DATA_WIDTH);

   spi_state_t             r_state, w_state_nxt;
   spi_mode_t              r_mode;
   logic [DATA_WIDTH-1:0]  r_tx_sr, r_rx_sr, r_rx_data;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [3:0]             r_count;
   logic                   r_miso, r_tx_load, r_rx_valid;

   logic w_sclk_rise, w_sclk_fall, w_unused_sclk_lvl;
   logic w_cs_sync, w_cs_fall, w_unused_cs_rise;
   logic w_mosi, w_lead, w_trail, w_sample, w_shift_out, w_word_done;
   logic w_load, w_load_phase;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
      .i_clk(i_clk), .i_reset(i_reset), .i_din(i_spi_clk),
      .o_level(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
      .i_clk(i_clk), .i_reset(i_reset), .i_din(i_cs),
      .o_level(w_cs_sync), .o_rise(w_unused_cs_rise), .o_fall(w_cs_fall)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) r_mosi_sync <= '0;
      else         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
   end
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   // Edge roles come from the mode latched at cs fall, never from the live pins.
   assign w_lead      = r_mode.polarity ? w_sclk_fall : w_sclk_rise;
   assign w_trail     = r_mode.polarity ? w_sclk_rise : w_sclk_fall;
   assign w_sample    = r_mode.phase ? w_trail : w_lead;
   // Phase 0: the trailing edge that closes a word arrives after DONE already presented the next MSB.
   assign w_shift_out = r_mode.phase ? w_lead : (w_trail && (r_count != 4'd0));
   assign w_word_done = (r_state == SHIFT) && w_sample && (r_count == LAST_BIT);
   assign w_load       = ((r_state == IDLE) && w_cs_fall) || (r_state == DONE);
   assign w_load_phase = (r_state == IDLE) ? i_phase : r_mode.phase;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= WAIT_CS;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT_CS: if (w_cs_sync) w_state_nxt = IDLE;
         IDLE:    if (w_cs_fall) w_state_nxt = SHIFT;
         SHIFT: begin
            if (w_word_done)    w_state_nxt = DONE;
            else if (w_cs_sync) w_state_nxt = IDLE;
         end
         DONE:    w_state_nxt = w_cs_sync ? IDLE : SHIFT;
         default: w_state_nxt = WAIT_CS;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mode     <= '0;
         r_tx_sr    <= '0;
         r_rx_sr    <= '0;
         r_rx_data  <= '0;
         r_count    <= '0;
         r_miso     <= 1'b0;
         r_tx_load  <= 1'b0;
         r_rx_valid <= 1'b0;
      end else begin
         r_tx_load  <= 1'b0;
         r_rx_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_count <= '0;
               if (w_cs_fall) r_mode <= '{polarity: i_polarity, phase: i_phase};
            end
            SHIFT: begin
               if (w_sample) begin
                  r_rx_sr <= {r_rx_sr[DATA_WIDTH-2:0], w_mosi};
                  if (r_count != FULL) r_count <= r_count + 4'd1;
               end
               if (w_cs_sync && !w_word_done) r_count <= '0;
            end
            DONE: begin
               r_rx_data  <= r_rx_sr;
               r_rx_valid <= 1'b1;
               r_count    <= '0;
            end
            default: r_count <= '0;
         endcase

         if (w_load) begin
            r_tx_load <= 1'b1;
            if (w_load_phase) begin
               r_tx_sr <= i_tx_data;
            end else begin
               r_tx_sr <= i_tx_data << 1;
               r_miso  <= i_tx_data[DATA_WIDTH-1];
            end
         end else if ((r_state == SHIFT) && w_shift_out) begin
            r_miso  <= r_tx_sr[DATA_WIDTH-1];
            r_tx_sr <= r_tx_sr << 1;
         end
         if (w_cs_sync) r_miso <= 1'b0;
      end
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   logic r_pending, r_overrun;

   // An ack landing with DONE retires the old word; the new one stays pending.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else if (r_state == DONE) begin
         r_pending <= 1'b1;
         if (r_pending && !i_rx_ack) r_overrun <= 1'b1;
         else if (i_rx_ack)          r_overrun <= 1'b0;
      end else if (i_rx_ack) begin
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end
   end
   assign o_overrun = r_overrun;
`else
   logic w_unused_ack;
   assign w_unused_ack = i_rx_ack;
   assign o_overrun    = 1'b0;
`endif

   assign o_miso     = w_cs_sync ? 1'b0 : r_miso;
   assign o_tx_load  = r_tx_load;
   assign o_rx_data  = r_rx_data;
   assign o_rx_valid = r_rx_valid;
   assign o_busy     = (r_state == SHIFT);
   assign o_state    = r_state;
   assign o_count    = r_count;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboarded bench for spi_slave: a bus-level SPI master drives frames, monitors pop expected words.
module tb_spi_slave;

   localparam int HALF = 8;

   logic       clk = 1'b0, reset = 1'b1;
   logic       polarity = 1'b0, phase = 1'b0;
   logic       spi_clk = 1'b0, cs = 1'b1, mosi = 1'b0, miso;
   logic [7:0] tx_data = 8'h5C, rx_data;
   logic       tx_load, rx_valid, rx_ack = 1'b0, overrun, busy;
   logic [1:0] state;
   logic [3:0] count;

   int         total = 0, bad = 0, loads = 0;
   int         m_pending = 0, m_ovr = 0;
   logic [7:0] rxq[$], txq[$], fwords[$];
   logic [7:0] w2;

   spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .i_clk(clk), .i_reset(reset), .i_polarity(polarity), .i_phase(phase),
      .i_spi_clk(spi_clk), .i_cs(cs), .i_mosi(mosi), .o_miso(miso),
      .i_tx_data(tx_data), .o_tx_load(tx_load), .o_rx_data(rx_data),
      .o_rx_valid(rx_valid), .i_rx_ack(rx_ack), .o_overrun(overrun),
      .o_busy(busy), .o_state(state), .o_count(count)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Every captured tx word is queued; tx_data then moves on to a fresh value.
   always @(negedge clk) begin
      if (!reset && tx_load) begin
         txq.push_back(tx_data);
         loads++;
         tx_data = 8'($urandom);
      end
   end

   always @(negedge clk) begin
      if (!reset && rx_valid) begin
         if (rxq.size() == 0) chk("rx_unexpected_valid", rx_valid, 0);
         else                 chk("rx_data", rx_data, rxq.pop_front());
         chk("rx_count_clear", count, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
         if (m_pending != 0) m_ovr = 1;
         m_pending = 1;
`endif
         chk("overrun", overrun, m_ovr);
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      cyc(4);
      rxq.delete();
      m_pending = 0;
      m_ovr = 0;
      reset = 1'b0;
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      cyc(1);
      rx_ack = 1'b0;
      m_pending = 0;
      m_ovr = 0;
      chk("overrun_ack", overrun, m_ovr);
   endtask

   // Sends nw full words (from fwords, else random) then part extra bits, then raises cs.
   task automatic frame(input logic pol, input logic pha, input int nw, input int part);
      logic [7:0] w, mw;
      int nb;
      polarity = pol;
      phase    = pha;
      spi_clk  = pol;
      mosi     = 1'b0;
      cyc(10);
      txq.delete();
      loads = 0;
      cs = 1'b0;
      cyc(8);
      for (int k = 0; k < nw + ((part > 0) ? 1 : 0); k++) begin
         w  = (fwords.size() != 0) ? fwords.pop_front() : 8'($urandom);
         nb = (k < nw) ? 8 : part;
         if (k < nw) rxq.push_back(w);
         mw = 8'h00;
         for (int i = 0; i < nb; i++) begin
            if (pha) spi_clk = ~pol;
            mosi = w[7-i];
            cyc(HALF);
            chk("busy", busy, 1);
            chk("count", count, i);
            mw = {mw[6:0], miso};
            spi_clk = pha ? pol : ~pol;
            if (k == 0 && i == 0) begin
               polarity = ~pol;
               phase    = ~pha;
            end
            cyc(HALF);
            if (!pha) spi_clk = pol;
         end
         if (nb == 8) begin
            if (txq.size() == 0) chk("miso_no_load", tx_load, 1);
            else                 chk("miso_word", mw, txq.pop_front());
         end
      end
      cyc(HALF);
      cs = 1'b1;
      cyc(12);
      chk("tx_loads", loads, nw + 1);
      chk("rx_missing", rxq.size(), 0);
      chk("end_state", state, 0);
      chk("end_busy", busy, 0);
      chk("end_miso", miso, 0);
      chk("end_count", count, 0);
   endtask

   task automatic reset_mid();
      polarity = 1'b0;
      phase    = 1'b0;
      spi_clk  = 1'b0;
      cyc(10);
      cs = 1'b0;
      cyc(8);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            reset = 1'b1;
            rxq.delete();
            m_pending = 0;
            m_ovr = 0;
            cyc(3);
            reset = 1'b0;
            cyc(4);
            chk("reset_mid_state", state, 3);
            chk("reset_mid_count", count, 0);
         end
         mosi = 1'($urandom);
         cyc(HALF);
         spi_clk = 1'b1;
         cyc(HALF);
         spi_clk = 1'b0;
      end
      chk("resync_hold", state, 3);
      cyc(HALF);
      cs = 1'b1;
      cyc(12);
      chk("resync_idle", state, 0);
   endtask

   initial begin
      cyc(3);
      chk("rst_miso", miso, 0);
      chk("rst_tx_load", tx_load, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
      chk("rst_state", state, 3);
      cyc(1);
      reset = 1'b0;

      fwords.push_back(8'hAB);
      frame(1'b0, 1'b0, 1, 0);

      do_reset();
      fwords.push_back(8'hAB);
      frame(1'b0, 1'b1, 1, 0);

      fwords.push_back(8'h3C);
      frame(1'b1, 1'b0, 1, 0);
      fwords.push_back(8'hC3);
      frame(1'b1, 1'b1, 1, 0);

      do_ack();
      fwords.push_back(8'h12);
      fwords.push_back(8'h34);
      frame(1'b0, 1'b0, 2, 0);

      do_ack();
      frame(1'b0, 1'b0, 0, 5);
      fwords.push_back(8'hA5);
      frame(1'b0, 1'b0, 1, 0);
      chk("a5_rx_data", rx_data, 8'hA5);
      reset_mid();
      frame(1'b1, 1'b0, 1, 0);

      do_ack();
      w2 = 8'($urandom);
      fwords.push_back(8'($urandom));
      fwords.push_back(w2);
      frame(1'b0, 1'b1, 2, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
      chk("ovr_two_words", overrun, 1);
`else
      chk("ovr_tied_low", overrun, 0);
`endif
      chk("ovr_rx_data", rx_data, w2);
      do_ack();

      for (int f = 0; f < 40; f++) begin
         frame(1'($urandom), 1'($urandom), $urandom_range(1, 3),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
         if ($urandom_range(0, 1) == 1) do_ack();
      end

      cyc(10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
